bp_trace_encoder_v2: RTL and testbench

BP_TRACE_ENCODER_V2 -- requirements
Module: bp_trace_encoder_v2

---
 rtl/bp_trace_encoder_v2_if.sv | 27 ++
 rtl/bp_trace_encoder_v2.sv | 138 +++++++++++++
 tb/tb_bp_trace_encoder_v2.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_trace_encoder_v2_if.sv
// Commit-side and trace-side signal bundle for the branch trace encoder.
// master = encoder side, slave = core/sink side.
interface bp_trace_encoder_v2_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int TS_WIDTH   = 16
);
    logic                  commit_valid_i;
    logic [ADDR_WIDTH-1:0] commit_pc_i;
    logic [1:0]            commit_priv_i;
    logic                  trace_valid_o;
    logic                  trace_ready_i;
    logic [5:0]            trace_mcode_o;
    logic [TS_WIDTH-1:0]   trace_ts_o;
    logic [ADDR_WIDTH-1:0] trace_addr_o;
    logic [1:0]            trace_priv_o;
    logic                  overflow_o;

    modport master (
        input  commit_valid_i, commit_pc_i, commit_priv_i, trace_ready_i,
        output trace_valid_o, trace_mcode_o, trace_ts_o, trace_addr_o, trace_priv_o, overflow_o
    );

    modport slave (
        output commit_valid_i, commit_pc_i, commit_priv_i, trace_ready_i,
        input  trace_valid_o, trace_mcode_o, trace_ts_o, trace_addr_o, trace_priv_o, overflow_o
    );
endinterface

// File: rtl/bp_trace_encoder_v2.sv
// Nexus-style branch trace encoder: suppresses sequential retirements, classifies
// discontinuities into COMPRESSED/DIRECT_BRANCH/SYNC/OVERFLOW and buffers them in a small FIFO.
module bp_trace_encoder_v2 #(
    parameter int ADDR_WIDTH   = 64,
    parameter int OFFSET_WIDTH = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int TS_WIDTH     = 16,
    parameter int SYNC_PERIOD  = 256
) (
    input logic                   clk_i,
    input logic                   reset_i,
    bp_trace_encoder_v2_if.master tr
);
    localparam logic [5:0] NEXUS_MCODE_DIRECT_BRANCH = 6'd3;
    localparam logic [5:0] NEXUS_MCODE_OVERFLOW      = 6'd8;
    localparam logic [5:0] NEXUS_MCODE_SYNC          = 6'd9;
    localparam logic [5:0] NEXUS_MCODE_COMPRESSED    = 6'd28;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(SYNC_PERIOD + 1);
    localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_PERIOD - 1);

    logic [ADDR_WIDTH-1:0] prev_pc;
    logic [1:0]            prev_priv;
    logic                  synced;
    logic                  pending_ovf;
    logic                  overflow_q;
    logic [TS_WIDTH-1:0]   ts_cnt;
    logic [CNT_W-1:0]      msg_cnt;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W:0]        count;

    logic [5:0]            fifo_mcode [FIFO_DEPTH];
    logic [TS_WIDTH-1:0]   fifo_ts    [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr  [FIFO_DEPTH];
    logic [1:0]            fifo_priv  [FIFO_DEPTH];

    logic [ADDR_WIDTH-1:0]            delta;
    logic [ADDR_WIDTH-OFFSET_WIDTH:0] delta_hi;
    logic priv_chg, fits, seq, msg, full, pop, push, drop;
    logic [5:0]            msg_mcode;
    logic [ADDR_WIDTH-1:0] msg_addr;

    assign delta    = tr.commit_pc_i - prev_pc;
    assign delta_hi = delta[ADDR_WIDTH-1:OFFSET_WIDTH-1];
    // Offset fits when every bit above the sign bit repeats the sign bit.
    assign fits     = (&delta_hi) | ~(|delta_hi);
    assign priv_chg = tr.commit_priv_i != prev_priv;
    assign seq      = synced && !priv_chg &&
                      (delta == ADDR_WIDTH'(2) || delta == ADDR_WIDTH'(4));
    assign msg      = tr.commit_valid_i && !seq;
    assign full     = count == DEPTH_C;
    assign pop      = (count != '0) && tr.trace_ready_i;
    assign push     = msg && (!full || pop);
    assign drop     = msg && full && !pop;

    always_comb begin
        msg_mcode = NEXUS_MCODE_DIRECT_BRANCH;
        msg_addr  = tr.commit_pc_i;
        if (pending_ovf) begin
            msg_mcode = NEXUS_MCODE_OVERFLOW;
        end else if (!synced || msg_cnt == SYNC_LAST) begin
            msg_mcode = NEXUS_MCODE_SYNC;
        end else if (!priv_chg && fits) begin
            msg_mcode = NEXUS_MCODE_COMPRESSED;
            msg_addr  = delta;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prev_pc     <= '0;
            prev_priv   <= '0;
            synced      <= 1'b0;
            pending_ovf <= 1'b0;
            overflow_q  <= 1'b0;
            ts_cnt      <= '0;
            msg_cnt     <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            if (tr.commit_valid_i) begin
                prev_pc   <= tr.commit_pc_i;
                prev_priv <= tr.commit_priv_i;
            end
            if (push)
                ts_cnt <= TS_WIDTH'(1);
            else if (!(&ts_cnt))
                ts_cnt <= ts_cnt + TS_WIDTH'(1);
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                case (msg_mcode)
                    NEXUS_MCODE_OVERFLOW: begin
                        pending_ovf <= 1'b0;
                        synced      <= 1'b1;
                        msg_cnt     <= '0;
                    end
                    NEXUS_MCODE_SYNC: begin
                        synced  <= 1'b1;
                        msg_cnt <= '0;
                    end
                    default: msg_cnt <= msg_cnt + CNT_W'(1);
                endcase
            end
            if (drop) begin
                pending_ovf <= 1'b1;
                overflow_q  <= 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk_i) begin
        if (push && !reset_i) begin
            fifo_mcode[wr_ptr] <= msg_mcode;
            fifo_ts[wr_ptr]    <= ts_cnt;
            fifo_addr[wr_ptr]  <= msg_addr;
            fifo_priv[wr_ptr]  <= tr.commit_priv_i;
        end
    end

    assign tr.trace_valid_o = count != '0;
    assign tr.trace_mcode_o = fifo_mcode[rd_ptr];
    assign tr.trace_ts_o    = fifo_ts[rd_ptr];
    assign tr.trace_addr_o  = fifo_addr[rd_ptr];
    assign tr.trace_priv_o  = fifo_priv[rd_ptr];
    assign tr.overflow_o    = overflow_q;
endmodule

// File: tb/tb_bp_trace_encoder_v2.sv
// Bench for bp_trace_encoder_v2: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based message model.
module tb_bp_trace_encoder_v2;
    localparam int AW = 64, OW = 16, FD = 4, TW = 4, SP = 8;
    localparam logic [5:0] MC_DB = 6'd3, MC_OVF = 6'd8, MC_SYNC = 6'd9, MC_CMP = 6'd28;
    localparam int TS_MAX = (1 << TW) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bp_trace_encoder_v2_if #(.ADDR_WIDTH(AW), .TS_WIDTH(TW)) tif ();

    bp_trace_encoder_v2 #(
        .ADDR_WIDTH(AW), .OFFSET_WIDTH(OW), .FIFO_DEPTH(FD), .TS_WIDTH(TW), .SYNC_PERIOD(SP)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .tr     (tif.master)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [5:0]  mcode;
        logic [63:0] addr;
        int          ts;
        logic [1:0]  priv;
    } msg_t;

    msg_t        mq[$];
    logic [63:0] m_prev_pc;
    logic [1:0]  m_prev_priv;
    bit          m_synced, m_pend, m_ovf;
    int          m_ts, m_cnt;

    typedef struct {
        bit          v;
        logic [63:0] pc;
        logic [1:0]  pr;
        bit          ev;
        logic [5:0]  emc;
        logic [63:0] ea;
        int          ets;
        logic [1:0]  ep;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input bit v, input logic [63:0] pc, input logic [1:0] pr);
        tif.commit_valid_i = v;
        tif.commit_pc_i    = pc;
        tif.commit_priv_i  = pr;
    endtask

    // Message-level reference: what each retirement produces, given the queue occupancy.
    task automatic model_step();
        logic [63:0] d;
        longint      sd;
        bit          do_pop, full, pushed, seq;
        msg_t        m;
        if (reset) begin
            mq.delete();
            m_prev_pc = '0; m_prev_priv = '0;
            m_synced = 0; m_pend = 0; m_ovf = 0; m_ts = 0; m_cnt = 0;
            return;
        end
        do_pop = (mq.size() > 0) && tif.trace_ready_i;
        full   = mq.size() == FD;
        pushed = 0;
        d  = tif.commit_pc_i - m_prev_pc;
        sd = longint'(signed'(d));
        seq = m_synced && tif.commit_priv_i == m_prev_priv && (sd == 2 || sd == 4);
        if (tif.commit_valid_i && !seq) begin
            m.addr = tif.commit_pc_i;
            if (m_pend) m.mcode = MC_OVF;
            else if (!m_synced || m_cnt == SP - 1) m.mcode = MC_SYNC;
            else if (tif.commit_priv_i != m_prev_priv) m.mcode = MC_DB;
            else if (sd >= -(longint'(1) << (OW - 1)) && sd < (longint'(1) << (OW - 1))) begin
                m.mcode = MC_CMP;
                m.addr  = d;
            end else m.mcode = MC_DB;
            m.ts   = m_ts;
            m.priv = tif.commit_priv_i;
            if (!full || do_pop) begin
                pushed = 1;
                if (m.mcode == MC_OVF) begin m_pend = 0; m_synced = 1; m_cnt = 0; end
                else if (m.mcode == MC_SYNC) begin m_synced = 1; m_cnt = 0; end
                else m_cnt++;
            end else begin
                m_pend = 1;
                m_ovf  = 1;
            end
        end
        if (tif.commit_valid_i) begin
            m_prev_pc   = tif.commit_pc_i;
            m_prev_priv = tif.commit_priv_i;
        end
        m_ts = pushed ? 1 : (m_ts < TS_MAX ? m_ts + 1 : TS_MAX);
        if (do_pop) void'(mq.pop_front());
        if (pushed) mq.push_back(m);
    endtask

    task automatic model_check();
        chk("m_valid", 64'(tif.trace_valid_o), 64'(mq.size() != 0));
        chk("m_overflow", 64'(tif.overflow_o), 64'(m_ovf));
        if (mq.size() > 0) begin
            chk("m_mcode", 64'(tif.trace_mcode_o), 64'(mq[0].mcode));
            chk("m_addr", tif.trace_addr_o, mq[0].addr);
            chk("m_ts", 64'(tif.trace_ts_o), 64'(mq[0].ts));
            chk("m_priv", 64'(tif.trace_priv_o), 64'(mq[0].priv));
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        model_check();
    endtask

    initial begin
        logic [63:0] cur_pc;
        logic [1:0]  cur_priv;
        longint      offs;
        longint      bnd[4];

        tbl[0]  = '{0, 64'h0,                   2'd0, 0, 6'd0,    64'h0,                   0, 2'd0};
        tbl[1]  = '{1, 64'h1000,                2'd0, 1, MC_SYNC, 64'h1000,                1, 2'd0};
        tbl[2]  = '{1, 64'h1004,                2'd0, 0, 6'd0,    64'h0,                   0, 2'd0};
        tbl[3]  = '{1, 64'h1008,                2'd0, 0, 6'd0,    64'h0,                   0, 2'd0};
        tbl[4]  = '{0, 64'h0,                   2'd0, 0, 6'd0,    64'h0,                   0, 2'd0};
        tbl[5]  = '{0, 64'h0,                   2'd0, 0, 6'd0,    64'h0,                   0, 2'd0};
        tbl[6]  = '{1, 64'h1010,                2'd0, 1, MC_CMP,  64'h8,                   5, 2'd0};
        tbl[7]  = '{1, 64'hFFFF_FFFF_8000_0000, 2'd0, 1, MC_DB,   64'hFFFF_FFFF_8000_0000, 1, 2'd0};
        tbl[8]  = '{1, 64'h1000,                2'd0, 1, MC_DB,   64'h1000,                1, 2'd0};
        tbl[9]  = '{1, 64'hFF0,                 2'd0, 1, MC_CMP,  64'hFFFF_FFFF_FFFF_FFF0, 1, 2'd0};
        tbl[10] = '{1, 64'hFF4,                 2'd3, 1, MC_DB,   64'hFF4,                 1, 2'd3};
        tbl[11] = '{1, 64'hFF4,                 2'd3, 1, MC_CMP,  64'h0,                   1, 2'd3};
        tbl[12] = '{1, 64'hFF8,                 2'd3, 0, 6'd0,    64'h0,                   0, 2'd0};
        tbl[13] = '{1, 64'h2000,                2'd3, 1, MC_CMP,  64'h1008,                2, 2'd3};
        tbl[14] = '{1, 64'h3000,                2'd3, 1, MC_SYNC, 64'h3000,                1, 2'd3};

        set_in(0, 64'h0, 2'd0);
        tif.trace_ready_i = 1'b1;
        reset = 1'b1;
        repeat (3) cycle();
        chk("reset_valid", 64'(tif.trace_valid_o), 64'd0);
        chk("reset_overflow", 64'(tif.overflow_o), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            set_in(tbl[i].v, tbl[i].pc, tbl[i].pr);
            cycle();
            chk($sformatf("vec%0d_valid", i), 64'(tif.trace_valid_o), 64'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d_mcode", i), 64'(tif.trace_mcode_o), 64'(tbl[i].emc));
                chk($sformatf("vec%0d_addr", i), tif.trace_addr_o, tbl[i].ea);
                chk($sformatf("vec%0d_ts", i), 64'(tif.trace_ts_o), 64'(tbl[i].ets));
                chk($sformatf("vec%0d_priv", i), 64'(tif.trace_priv_o), 64'(tbl[i].ep));
            end
        end

        // Backpressure: 6 discontinuities into a 4-deep FIFO.
        set_in(0, 64'h0, 2'd3);
        cycle();
        tif.trace_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_in(1, 64'h10000 + 64'(i) * 64'h100, 2'd3);
            cycle();
        end
        chk("ovf_sticky", 64'(tif.overflow_o), 64'd1);
        chk("ovf_head_valid", 64'(tif.trace_valid_o), 64'd1);
        set_in(0, 64'h0, 2'd3);
        tif.trace_ready_i = 1'b1;
        repeat (3) cycle();
        chk("drain_3_left1", 64'(tif.trace_valid_o), 64'd1);
        cycle();
        chk("drain_4_empty", 64'(tif.trace_valid_o), 64'd0);
        set_in(1, 64'h5000, 2'd3);
        cycle();
        chk("ovf_msg_mcode", 64'(tif.trace_mcode_o), 64'(MC_OVF));
        chk("ovf_msg_addr", tif.trace_addr_o, 64'h5000);

        // Long idle gap saturates the timestamp.
        set_in(0, 64'h0, 2'd3);
        repeat (40) cycle();
        set_in(1, 64'h9000, 2'd3);
        cycle();
        chk("ts_saturated", 64'(tif.trace_ts_o), 64'(TS_MAX));

        // Reset with entries queued.
        set_in(0, 64'h0, 2'd3);
        cycle();
        tif.trace_ready_i = 1'b0;
        set_in(1, 64'hA000, 2'd3); cycle();
        set_in(1, 64'hB000, 2'd3); cycle();
        set_in(1, 64'hC000, 2'd3); cycle();
        chk("pre_reset_valid", 64'(tif.trace_valid_o), 64'd1);
        reset = 1'b1;
        set_in(1, 64'hD000, 2'd3);
        cycle();
        chk("reset_flush_valid", 64'(tif.trace_valid_o), 64'd0);
        chk("reset_flush_ovf", 64'(tif.overflow_o), 64'd0);
        reset = 1'b0;
        tif.trace_ready_i = 1'b1;
        set_in(1, 64'h1234, 2'd0);
        cycle();
        chk("first_after_reset_sync", 64'(tif.trace_mcode_o), 64'(MC_SYNC));

        // Randomized traffic against the model.
        bnd[0] = 32767; bnd[1] = -32768; bnd[2] = 32768; bnd[3] = -32769;
        cur_pc   = 64'h1234;
        cur_priv = 2'd0;
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: cur_pc = cur_pc + 64'd4;
                4: cur_pc = cur_pc + 64'd2;
                5: ;
                6: begin
                    offs = longint'($urandom_range(0, 65535)) - 32768;
                    cur_pc = cur_pc + 64'(offs);
                end
                7: cur_pc = {$urandom(), $urandom()};
                8: cur_pc = cur_pc + 64'(bnd[$urandom_range(0, 3)]);
                default: begin
                    cur_pc = cur_pc + 64'd4;
                    cur_priv = 2'($urandom_range(0, 3));
                end
            endcase
            set_in($urandom_range(0, 3) != 0, cur_pc, cur_priv);
            if ((n / 50) % 4 == 3) tif.trace_ready_i = ($urandom_range(0, 7) == 0);
            else tif.trace_ready_i = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 999) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
